// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional build macro: RF_DIFFTEST_EN (adds the regs_o snapshot port on regfile_mp).
// wr_winner() resolves write ports at fixed maximum sizes: up to 8 write
// ports, 8 address bits and 64 data bits. Callers zero-extend their vectors
// and tie unused enables low.
package rf_pkg;

  localparam int RF_XLEN = 64;
  localparam int RF_NREG = 32;
  localparam int RF_AW   = $clog2(RF_NREG);

  typedef logic [RF_AW-1:0] rf_addr_t;

  localparam rf_addr_t REG_ZERO = '0;

  localparam int WW_MAX_NWR  = 8;
  localparam int WW_MAX_AW   = 8;
  localparam int WW_MAX_XLEN = 64;

  typedef struct packed {
    logic                   hit;
    logic [WW_MAX_XLEN-1:0] data;
  } wr_hit_t;

  // Priority resolve for one register address: the highest-index enabled
  // port that targets the address wins. Address zero never hits.
  function automatic wr_hit_t wr_winner(
    input logic [WW_MAX_AW-1:0]              a,
    input logic [WW_MAX_NWR-1:0]             en,
    input logic [WW_MAX_NWR*WW_MAX_AW-1:0]   addr,
    input logic [WW_MAX_NWR*WW_MAX_XLEN-1:0] data
  );
    wr_hit_t res;
    res = '0;
    if (a != WW_MAX_AW'(REG_ZERO)) begin
      for (int i = 0; i < WW_MAX_NWR; i++) begin
        if (en[i] && (addr[i*WW_MAX_AW +: WW_MAX_AW] == a)) begin
          res.hit  = 1'b1;
          res.data = data[i*WW_MAX_XLEN +: WW_MAX_XLEN];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one bit per architectural register.
// Allocation marks a register pending, write-back clears it, and a
// same-cycle allocation wins over the clear. Register 0 is never pending.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int NRD  = 4,
  parameter int NAL  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NRD*AW-1:0] rd_addr_i,
  input  logic [NREG-1:0] wr_hit_i,
  input  logic [NAL-1:0]  al_en_i,
  input  logic [NAL*AW-1:0] al_addr_i,
  output logic [NRD-1:0]  rd_rdy_o,
  output logic            any_pend_o
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Next pending state: hold, clear on write-back, set on allocation (set wins).
  always_comb begin
    pend_d    = pend_q;
    pend_d[0] = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (wr_hit_i[r]) pend_d[r] = 1'b0;
      for (int a = 0; a < NAL; a++) begin
        if (al_en_i[a] && (al_addr_i[a*AW +: AW] == AW'(r))) pend_d[r] = 1'b1;
      end
    end
  end

  // Pending bit register; reset drops every outstanding producer.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rdy
    logic [AW-1:0] a;
    logic          valid;
    assign a     = rd_addr_i[p*AW +: AW];
    assign valid = (a != AW'(REG_ZERO)) && (int'(a) < NREG);
    assign rd_rdy_o[p] = ~valid | wr_hit_i[a] | ~pend_q[a];
  end

  assign any_pend_o = |pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write->read bypass and a
// per-register pending scoreboard (rf_scoreboard).
// Optional build macro: RF_DIFFTEST_EN adds the regs_o post-bypass snapshot.
// Supported sizes: XLEN <= 64, NWR <= 8, AW <= 8.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int NRD  = 4,
  parameter int NWR  = 2,
  parameter int NAL  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_rdy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic [NAL-1:0]       al_en,
  input  logic [NAL*AW-1:0]    al_addr,
  output logic                 any_pend
`ifdef RF_DIFFTEST_EN
  ,
  output logic [NREG*XLEN-1:0] regs_o
`endif
);

  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [NREG-1:0][XLEN-1:0] regs_d;

  logic [WW_MAX_NWR-1:0]             wen_x;
  logic [WW_MAX_NWR*WW_MAX_AW-1:0]   waddr_x;
  logic [WW_MAX_NWR*WW_MAX_XLEN-1:0] wdata_x;

  wr_hit_t [NREG-1:1] wr_res;
  logic [NREG-1:0]    wr_hit;

  // Widen the write ports to the resolver's fixed layout; unused ports stay disabled.
  always_comb begin
    wen_x   = '0;
    waddr_x = '0;
    wdata_x = '0;
    for (int w = 0; w < NWR; w++) begin
      wen_x[w] = wr_en[w];
      waddr_x[w*WW_MAX_AW +: WW_MAX_AW]     = WW_MAX_AW'(wr_addr[w*AW +: AW]);
      wdata_x[w*WW_MAX_XLEN +: WW_MAX_XLEN] = WW_MAX_XLEN'(wr_data[w*XLEN +: XLEN]);
    end
  end

  // Post-bypass view per register: winning write this cycle, else stored value.
  // This is both the next state of the array and the source for all reads.
  always_comb begin
    wr_res = '0;
    wr_hit = '0;
    regs_d = '0;
    for (int r = 1; r < NREG; r++) begin
      wr_res[r] = wr_winner(WW_MAX_AW'(r), wen_x, waddr_x, wdata_x);
      wr_hit[r] = wr_res[r].hit;
      regs_d[r] = wr_res[r].hit ? wr_res[r].data[XLEN-1:0] : regs_q[r];
    end
  end

  // Data array; register 0 has no storage.
  always_ff @(posedge clk) begin
    for (int r = 1; r < NREG; r++) begin
      if (rst) regs_q[r] <= '0;
      else     regs_q[r] <= regs_d[r];
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          valid;
    assign a     = rd_addr[p*AW +: AW];
    assign valid = (a != AW'(REG_ZERO)) && (int'(a) < NREG);
    assign rd_data[p*XLEN +: XLEN] = valid ? regs_d[a] : '0;
  end

  rf_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NAL  (NAL),
    .AW   (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr),
    .wr_hit_i   (wr_hit),
    .al_en_i    (al_en),
    .al_addr_i  (al_addr),
    .rd_rdy_o   (rd_rdy),
    .any_pend_o (any_pend)
  );

`ifdef RF_DIFFTEST_EN
  assign regs_o = regs_d;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a behavioural register/pending model
// produces expectations that are queued when stimulus is applied and popped
// when the combinational outputs are sampled mid-cycle.
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int NAL  = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_rdy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic [NAL-1:0]       al_en;
  logic [NAL*AW-1:0]    al_addr;
  logic                 any_pend;
`ifdef RF_DIFFTEST_EN
  logic [NREG*XLEN-1:0] regs_o;
`endif

  regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .NAL(NAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_rdy   (rd_rdy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .al_en    (al_en),
    .al_addr  (al_addr),
    .any_pend (any_pend)
`ifdef RF_DIFFTEST_EN
    ,
    .regs_o   (regs_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*XLEN-1:0]  d;
    logic [NRD-1:0]       r;
    logic                 a;
    logic [NREG*XLEN-1:0] snap;
  } exp_t;

  exp_t eq[$];

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_pend [NREG];

  int checks = 0;
  int errors = 0;

  task automatic drive_idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    al_en = '0; al_addr = '0; rd_addr = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int w, input int a, input logic [XLEN-1:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = AW'(a);
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic set_al(input int s, input int a);
    al_en[s] = 1'b1;
    al_addr[s*AW +: AW] = AW'(a);
  endtask

  task automatic rd_all(input int a);
    for (int p = 0; p < NRD; p++) set_rd(p, a);
  endtask

  // Highest-index enabled write to a nonzero address wins.
  function automatic void wr_match(input int a, output bit hit, output logic [XLEN-1:0] d);
    hit = 1'b0; d = '0;
    if (a != 0)
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
          hit = 1'b1; d = wr_data[w*XLEN +: XLEN];
        end
  endfunction

  function automatic void exp_read(input int a, output logic [XLEN-1:0] d, output logic r);
    bit hit;
    logic [XLEN-1:0] wd;
    wr_match(a, hit, wd);
    if (a == 0)   begin d = '0;        r = 1'b1;        end
    else if (hit) begin d = wd;        r = 1'b1;        end
    else          begin d = m_regs[a]; r = ~m_pend[a];  end
  endfunction

  task automatic push_exp();
    exp_t e;
    logic [XLEN-1:0] dd;
    logic rr;
    bit ap;
    ap = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      exp_read(int'(rd_addr[p*AW +: AW]), dd, rr);
      e.d[p*XLEN +: XLEN] = dd;
      e.r[p] = rr;
    end
    for (int r = 0; r < NREG; r++) begin
      exp_read(r, dd, rr);
      e.snap[r*XLEN +: XLEN] = dd;
      ap |= m_pend[r];
    end
    e.a = ap;
    eq.push_back(e);
  endtask

  task automatic model_edge();
    bit hit, alloc;
    logic [XLEN-1:0] wd;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin m_regs[r] = '0; m_pend[r] = 1'b0; end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        wr_match(r, hit, wd);
        alloc = 1'b0;
        for (int s = 0; s < NAL; s++)
          if (al_en[s] && int'(al_addr[s*AW +: AW]) == r) alloc = 1'b1;
        if (alloc)    m_pend[r] = 1'b1;
        else if (hit) m_pend[r] = 1'b0;
        if (hit) m_regs[r] = wd;
      end
    end
  endtask

  task automatic adv();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    drive_idle();
    rst = 1'b1;
    set_wr(0, 5, 64'h1234); set_wr(1, 6, 64'h5678);
    set_al(0, 9); set_al(1, 3);
    rd_all(5);
    adv();
    rst = 1'b0;
    drive_idle();
    set_rd(0, 5); set_rd(1, 6); set_rd(2, 9); set_rd(3, 3);
    push_exp();
    #1;
    e = eq.pop_front();
    checks++;
    if (rd_data !== e.d) begin errors++; $display("FAIL reset rd_data got %h exp %h", rd_data, e.d); end
    checks++;
    if (rd_rdy !== e.r) begin errors++; $display("FAIL reset rd_rdy got %b exp %b", rd_rdy, e.r); end
    checks++;
    if (any_pend !== 1'b0) begin errors++; $display("FAIL reset any_pend got %b exp 0", any_pend); end
    checks++;
    if (rd_data !== '0 || rd_rdy !== '1) begin
      errors++; $display("FAIL reset_const rd_data %h rd_rdy %b exp all zero / all one", rd_data, rd_rdy);
    end
    adv();
  endtask

  task automatic run_steps(input string nm, input int nsteps, input int which);
    exp_t e;
    for (int s = 0; s < nsteps; s++) begin
      drive_idle();
      case (which)
        2: case (s)
             0: begin set_wr(0, 5, 64'hDEAD); set_rd(0, 5); set_rd(1, 0); set_rd(2, 6); set_rd(3, 5); end
             default: rd_all(5);
           endcase
        3: case (s)
             0: begin set_wr(0, 7, 64'h11); set_wr(1, 7, 64'h22); rd_all(7); end
             default: rd_all(7);
           endcase
        4: case (s)
             0: begin set_al(0, 9); rd_all(9); end
             1: rd_all(9);
             2: begin set_wr(1, 9, 64'h5); rd_all(9); end
             default: rd_all(9);
           endcase
        default: case (s)
             0: begin set_al(0, 3); set_wr(0, 3, 64'h33); rd_all(3); end
             1: rd_all(3);
             2: begin set_wr(1, 0, 64'hFF); set_al(1, 0); set_wr(0, 3, 64'h34);
                      set_rd(0, 0); set_rd(1, 0); set_rd(2, 3); set_rd(3, 0); end
             default: begin set_rd(0, 0); set_rd(1, 3); set_rd(2, 0); set_rd(3, 3); end
           endcase
      endcase
      push_exp();
      #1;
      e = eq.pop_front();
      checks++;
      if (rd_data !== e.d) begin errors++; $display("FAIL %s step %0d rd_data got %h exp %h", nm, s, rd_data, e.d); end
      checks++;
      if (rd_rdy !== e.r) begin errors++; $display("FAIL %s step %0d rd_rdy got %b exp %b", nm, s, rd_rdy, e.r); end
      checks++;
      if (any_pend !== e.a) begin errors++; $display("FAIL %s step %0d any_pend got %b exp %b", nm, s, any_pend, e.a); end
      adv();
    end
  endtask

  task automatic test_bypass();
    run_steps("bypass", 2, 2);
    drive_idle(); rd_all(5); #1;
    checks++;
    if (rd_data[XLEN-1:0] !== 64'hDEAD) begin errors++; $display("FAIL bypass_stored got %h exp dead", rd_data[XLEN-1:0]); end
  endtask

  task automatic test_wr_priority();
    run_steps("wr_priority", 3, 3);
    drive_idle(); rd_all(7); #1;
    checks++;
    if (rd_data[XLEN-1:0] !== 64'h22) begin errors++; $display("FAIL wr_priority_const got %h exp 22", rd_data[XLEN-1:0]); end
  endtask

  task automatic test_pending();
    run_steps("pending", 4, 4);
  endtask

  task automatic test_alloc_vs_wr();
    run_steps("alloc_vs_wr", 4, 5);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive_idle(); set_al(0, 4); rd_all(4);
    push_exp(); #1;
    e = eq.pop_front();
    checks++;
    if (rd_rdy !== e.r) begin errors++; $display("FAIL reset_mid alloc rd_rdy got %b exp %b", rd_rdy, e.r); end
    adv();
    drive_idle(); rd_all(4); #1;
    checks++;
    if (any_pend !== 1'b1) begin errors++; $display("FAIL reset_mid pend_before got %b exp 1", any_pend); end
    rst = 1'b1; set_wr(0, 4, 64'h44); set_al(1, 4);
    adv();
    rst = 1'b0; drive_idle(); rd_all(4);
    push_exp(); #1;
    e = eq.pop_front();
    checks++;
    if (rd_data !== e.d || rd_data !== '0) begin errors++; $display("FAIL reset_mid rd_data got %h exp %h", rd_data, e.d); end
    checks++;
    if (rd_rdy !== e.r || rd_rdy !== '1) begin errors++; $display("FAIL reset_mid rd_rdy got %b exp %b", rd_rdy, e.r); end
    checks++;
    if (any_pend !== 1'b0) begin errors++; $display("FAIL reset_mid any_pend got %b exp 0", any_pend); end
`ifdef RF_DIFFTEST_EN
    checks++;
    if (regs_o[4*XLEN +: XLEN] !== '0) begin errors++; $display("FAIL reset_mid regs_o4 got %h exp 0", regs_o[4*XLEN +: XLEN]); end
`endif
    adv();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int s = 0; s < 300; s++) begin
      drive_idle();
      for (int w = 0; w < NWR; w++)
        if ($urandom_range(0, 2) != 0) set_wr(w, $urandom_range(0, 31), {$urandom, $urandom});
      for (int a = 0; a < NAL; a++)
        if ($urandom_range(0, 3) == 0) set_al(a, $urandom_range(0, 31));
      for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 31));
      push_exp();
      #1;
      e = eq.pop_front();
      checks++;
      if (rd_data !== e.d) begin errors++; $display("FAIL b2b step %0d rd_data got %h exp %h", s, rd_data, e.d); end
      checks++;
      if (rd_rdy !== e.r) begin errors++; $display("FAIL b2b step %0d rd_rdy got %b exp %b", s, rd_rdy, e.r); end
      checks++;
      if (any_pend !== e.a) begin errors++; $display("FAIL b2b step %0d any_pend got %b exp %b", s, any_pend, e.a); end
`ifdef RF_DIFFTEST_EN
      checks++;
      if (regs_o !== e.snap) begin
        errors++;
        for (int r = 0; r < NREG; r++)
          if (regs_o[r*XLEN +: XLEN] !== e.snap[r*XLEN +: XLEN]) begin
            $display("FAIL b2b step %0d regs_o[%0d] got %h exp %h", s, r,
                     regs_o[r*XLEN +: XLEN], e.snap[r*XLEN +: XLEN]);
            break;
          end
      end
`endif
      adv();
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_bypass();
    test_wr_priority();
    test_pending();
    test_alloc_vs_wr();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
